serial_rx_fifo: RTL and testbench
=================================

# serial_rx_fifo

Serial receive front-end for the Altair SIO path. It sits between the board `rx` pin and the CPU-side 6850-style serial port. It deserialises 8N1 async frames with 16x oversampling and buffers the bytes in a FIFO. The port drains the FIFO through a one-cycle pop strobe, so console input survives while the CPU is slowed by `ce` gating or paused in single-step mode.

## Interface
Parameters:
- `CLK_HZ`, 25000000: system clock frequency.
- `BAUD`, 115200: line rate. Oversample divisor `DIV = CLK_HZ/(BAUD*16)`, truncated, minimum 1.
- `DEPTH_LOG2`, 4: FIFO depth is `2**DEPTH_LOG2` (16).

Ports (reset reset, synchronous, active-high; clock clk):
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `rx`  in  1  async serial line, idle high.
- `rd`  in  1  pop strobe, one cycle per byte; not qualified by `ce`.
- `clr_err`  in  1  clears the sticky error flags.
- `rd_data`  out  8  head of FIFO (first-word-fall-through).
- `rx_avail`  out  1  FIFO non-empty.
- `rx_full`  out  1  FIFO holds `2**DEPTH_LOG2` bytes.
- `count`  out  DEPTH_LOG2+1  current occupancy.
- `overrun`  out  1  sticky: a byte arrived while the FIFO was full.
- `framing_err`  out  1  sticky: stop bit sampled low.

## Operation
- `rx` passes through a 2-FF synchroniser, initialised high. The FSM sees only the synchronised `rxs`.
- A tick counter divides `clk` by `DIV` and produces a one-cycle `tick`. The counter runs freely.
- Receive FSM, with a 4-bit sub-tick counter `st` and a 3-bit bit index `bi`:
  - IDLE: on falling `rxs`, go to START with `st=0`.
  - START: at `st==7` (mid start bit), go to DATA if `rxs==0`, else return to IDLE (glitch rejected). Then reset `st=0`.
  - DATA: at every `st==15`, shift `rxs` into the MSB of the shift register (LSB-first line order). After `bi==7`, go to STOP.
  - STOP: at `st==15`:
    - if `rxs==1`, request a push;
    - else set `framing_err` and discard the byte.
    - Return to IDLE in either case.
- FIFO: a circular buffer with `DEPTH_LOG2`-bit read/write pointers that wrap modulo depth, plus a separate `count`.
  - Push when FIFO full: byte dropped, `overrun` set, pointers unchanged.
  - `rd` when empty: ignored, with no underflow.
  - Push and pop in the same cycle: both execute and `count` is unchanged. This includes the full case: when full and popping, the push is accepted and `overrun` is not set.
- `rd_data` = memory[rd_ptr] when non-empty, else 8'h00.
- Error flags: set by events, cleared by `clr_err`. A set and a clear in the same cycle resolve to set.
- `reset` mid-frame: the FSM returns to IDLE, the partial byte is discarded, and the FIFO is emptied.

## Timing
- Reset values: `rd_data=8'h00`, `rx_avail=0`, `rx_full=0`, `count=0`, `overrun=0`, `framing_err=0`. The FSM is in IDLE and the synchroniser holds 1.
- Input latency: 2 `clk` cycles from `rx` to `rxs`.
- A push occurs on the `clk` edge of the STOP `st==15` tick. `rx_avail`, `count` and `rd_data` update on that same edge and are visible the following cycle.
- Pop: `rd` sampled high at edge N. The next byte (or 8'h00) is on `rd_data` after edge N, and `count` decrements at N.
- Nominal push occurs about 9.5 bit times after the start edge, ±1 tick plus 2 cycles.
- A new start bit is accepted in IDLE immediately after STOP, which allows back-to-back frames.

## Test plan
- Single byte, with `CLK_HZ=1843200`, `BAUD=115200` (so `DIV=1`): send 0x55, then `rx_avail=1`, `count=1`, `rd_data=0x55`. Pulse `rd`; next cycle `rx_avail=0` and `rd_data=0x00`.
- Glitch: drive `rx` low for 4 ticks, then high. Required: no push, FSM back in IDLE, `count=0`.
- Fill and overrun: send 17 bytes 0x00..0x10 without reading. Required: `rx_full=1`, `count=16`, `overrun=1`. Sixteen pops return 0x00..0x0F in order, and pointers wrap cleanly on a further 4 bytes.
- Framing: send 0xA3 with the stop bit low. Required: `framing_err=1` and `count` unchanged. `clr_err` clears the flag. `clr_err` asserted coincident with a new error leaves the flag at 1.
- Simultaneous push/pop: with `count=16`, assert `rd` on the push edge. Required: `count` stays 16, `overrun=0`, and the new byte is last in read order.
- Reset mid-frame: assert `reset` during DATA `bi=4` with 3 bytes queued. Required: all outputs at reset values. A following 0x7E frame is received correctly.

Source files
------------

// File: rtl/serial_rx_fifo.sv
// 8N1 serial receiver with 16x oversampling feeding a first-word-fall-through FIFO.
// Decoupled from CPU speed so console bytes survive ce gating and single-step pauses.
module serial_rx_fifo #(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic [7:0]            rd_data,
    output logic                  rx_avail,
    output logic                  rx_full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    output logic                  framing_err
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int CNT_W   = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic                  r_rx_meta;
    logic                  r_rxs;
    logic                  r_rxs_q;
    logic [TW-1:0]         r_tick_cnt;
    logic                  w_tick;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_st;
    logic [3:0]            w_st_nxt;
    logic [2:0]            r_bi;
    logic [2:0]            w_bi_nxt;
    logic [7:0]            r_shift;
    logic [7:0]            w_shift_nxt;
    logic                  w_push_req;
    logic                  w_frame_err;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overrun;
    logic                  r_framing_err;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_en;
    logic                  w_wr_en;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_rxs_q   <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
            r_rxs_q   <= r_rxs;
        end
    end

    assign w_tick = (r_tick_cnt == TW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset)
            r_tick_cnt <= '0;
        else if (w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_st    <= '0;
            r_bi    <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_st    <= w_st_nxt;
            r_bi    <= w_bi_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_st_nxt    = r_st;
        w_bi_nxt    = r_bi;
        w_shift_nxt = r_shift;
        w_push_req  = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_rxs_q && !r_rxs) begin
                    w_state_nxt = S_START;
                    w_st_nxt    = '0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (r_st == 4'd7) begin
                        w_st_nxt    = '0;
                        w_bi_nxt    = '0;
                        w_state_nxt = r_rxs ? S_IDLE : S_DATA;
                    end else begin
                        w_st_nxt = r_st + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    // st wraps 15 -> 0, so each bit and the stop bit restart mid-cell aligned
                    w_st_nxt = r_st + 4'd1;
                    if (r_st == 4'd15) begin
                        w_shift_nxt = {r_rxs, r_shift[7:1]};
                        if (r_bi == 3'd7)
                            w_state_nxt = S_STOP;
                        else
                            w_bi_nxt = r_bi + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_st == 4'd15) begin
                        w_push_req  = r_rxs;
                        w_frame_err = !r_rxs;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_st_nxt = r_st + 4'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_rd_en = rd && !w_empty;
    // a pop on the same edge frees the slot, so a push into a full FIFO still lands
    assign w_wr_en = w_push_req && (!w_full || w_rd_en);

    // NOTE: the storage array has no reset; occupancy is tracked by pointers and count,
    // and rd_data is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overrun     <= 1'b0;
            r_framing_err <= 1'b0;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_wr_en)
                r_overrun <= 1'b1;
            else if (clr_err)
                r_overrun <= 1'b0;
            if (w_frame_err)
                r_framing_err <= 1'b1;
            else if (clr_err)
                r_framing_err <= 1'b0;
        end
    end

    assign rd_data     = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign rx_avail    = !w_empty;
    assign rx_full     = w_full;
    assign count       = r_count;
    assign overrun     = r_overrun;
    assign framing_err = r_framing_err;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Directed bench for serial_rx_fifo at DIV=1 (16 clocks per bit, 160 clocks per frame).
// Expected values are hand-derived constants; outputs are sampled 1ns after the rising edge.
module tb_serial_rx_fifo;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rd;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rx_avail;
    logic       rx_full;
    logic [4:0] count;
    logic       overrun;
    logic       framing_err;

    int n_checks = 0;
    int n_fail   = 0;

    serial_rx_fifo #(
        .CLK_HZ    (1843200),
        .BAUD      (115200),
        .DEPTH_LOG2(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rd         (rd),
        .clr_err    (clr_err),
        .rd_data    (rd_data),
        .rx_avail   (rx_avail),
        .rx_full    (rx_full),
        .count      (count),
        .overrun    (overrun),
        .framing_err(framing_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one 160-cycle frame. rd/clr_err pulse at cycle index rd_at/clr_at; a
    // reset at rst_at aborts the frame with the line returned to idle. -1 disables each.
    // A push lands on the edge that samples cycle index 154.
    task automatic frame(input logic [7:0] d, input logic stop, input int rd_at,
                         input int clr_at, input int rst_at);
        for (int c = 0; c < 160; c++) begin
            int b;
            b = c / 16;
            if (c == rst_at) begin
                reset = 1'b1;
                rx    = 1'b1;
                rd    = 1'b0;
                step(1);
                reset = 1'b0;
                return;
            end
            if (b == 0)      rx = 1'b0;
            else if (b == 9) rx = stop;
            else             rx = d[b-1];
            rd      = (c == rd_at);
            clr_err = (c == clr_at);
            step(1);
        end
        rx      = 1'b1;
        rd      = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        frame(d, 1'b1, -1, -1, -1);
    endtask

    task automatic pop;
        rd = 1'b1;
        step(1);
        rd = 1'b0;
    endtask

    task automatic test_reset;
        n_checks++;
        if (rd_data !== 8'h00 || rx_avail !== 1'b0 || rx_full !== 1'b0 || count !== 5'd0 ||
            overrun !== 1'b0 || framing_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rd_data=%h avail=%b full=%b count=%0d ovr=%b ferr=%b, required 00/0/0/0/0/0",
                     rd_data, rx_avail, rx_full, count, overrun, framing_err);
        end
    endtask

    task automatic test_single_byte;
        send(8'h55);
        step(4);
        n_checks++;
        if (rx_avail !== 1'b1 || count !== 5'd1 || rd_data !== 8'h55) begin
            n_fail++;
            $display("FAIL single_byte: avail=%b count=%0d rd_data=%h, required 1/1/55", rx_avail, count, rd_data);
        end
        pop();
        n_checks++;
        if (rx_avail !== 1'b0 || rd_data !== 8'h00 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL single_pop: avail=%b count=%0d rd_data=%h, required 0/0/00", rx_avail, count, rd_data);
        end
        pop();
        n_checks++;
        if (count !== 5'd0 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL underflow: count=%0d rd_data=%h, required 0/00", count, rd_data);
        end
    endtask

    task automatic test_glitch;
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(30);
        n_checks++;
        if (count !== 5'd0 || rx_avail !== 1'b0 || framing_err !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch: count=%0d avail=%b ferr=%b, required 0/0/0", count, rx_avail, framing_err);
        end
        send(8'h3C);
        step(2);
        n_checks++;
        if (count !== 5'd1 || rd_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL after_glitch: count=%0d rd_data=%h, required 1/3c", count, rd_data);
        end
        pop();
    endtask

    task automatic test_fill_overrun;
        for (int i = 0; i < 17; i++) send(8'(i));
        step(2);
        n_checks++;
        if (rx_full !== 1'b1 || count !== 5'd16 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL fill: full=%b count=%0d ovr=%b, required 1/16/1", rx_full, count, overrun);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (rd_data !== 8'(i)) begin
                n_fail++;
                $display("FAIL fill_order[%0d]: rd_data=%h, required %h", i, rd_data, 8'(i));
            end
            pop();
        end
        n_checks++;
        if (rx_avail !== 1'b0 || count !== 5'd0 || rx_full !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: avail=%b count=%0d full=%b, required 0/0/0", rx_avail, count, rx_full);
        end
        for (int i = 0; i < 4; i++) send(8'h20 + 8'(i));
        step(2);
        n_checks++;
        if (count !== 5'd4) begin
            n_fail++;
            $display("FAIL wrap_count: count=%0d, required 4", count);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_data !== 8'h20 + 8'(i)) begin
                n_fail++;
                $display("FAIL wrap_order[%0d]: rd_data=%h, required %h", i, rd_data, 8'h20 + 8'(i));
            end
            pop();
        end
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: ovr=%b, required 0", overrun);
        end
    endtask

    task automatic test_framing;
        frame(8'hA3, 1'b0, -1, -1, -1);
        step(2);
        n_checks++;
        if (framing_err !== 1'b1 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL framing: ferr=%b count=%0d, required 1/0", framing_err, count);
        end
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        n_checks++;
        if (framing_err !== 1'b0) begin
            n_fail++;
            $display("FAIL framing_clear: ferr=%b, required 0", framing_err);
        end
        frame(8'hA3, 1'b0, -1, 154, -1);
        step(2);
        n_checks++;
        if (framing_err !== 1'b1 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL framing_set_wins: ferr=%b count=%0d, required 1/0", framing_err, count);
        end
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 16; i++) send(8'h40 + 8'(i));
        step(2);
        n_checks++;
        if (count !== 5'd16 || rx_full !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_fill: count=%0d full=%b ovr=%b, required 16/1/0", count, rx_full, overrun);
        end
        frame(8'h99, 1'b1, 154, -1, -1);
        step(2);
        n_checks++;
        if (count !== 5'd16 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL push_pop_full: count=%0d ovr=%b, required 16/0", count, overrun);
        end
        for (int i = 1; i < 17; i++) begin
            logic [7:0] exp;
            exp = (i == 16) ? 8'h99 : 8'h40 + 8'(i);
            n_checks++;
            if (rd_data !== exp) begin
                n_fail++;
                $display("FAIL push_pop_order[%0d]: rd_data=%h, required %h", i, rd_data, exp);
            end
            pop();
        end
    endtask

    task automatic test_reset_mid_frame;
        send(8'h11);
        send(8'h22);
        send(8'h33);
        step(2);
        n_checks++;
        if (count !== 5'd3) begin
            n_fail++;
            $display("FAIL pre_reset_count: count=%0d, required 3", count);
        end
        frame(8'h00, 1'b1, -1, -1, 80);
        test_reset();
        step(20);
        send(8'h7E);
        step(2);
        n_checks++;
        if (count !== 5'd1 || rd_data !== 8'h7E || framing_err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_frame: count=%0d rd_data=%h ferr=%b, required 1/7e/0", count, rd_data, framing_err);
        end
    endtask

    initial begin
        reset   = 1'b1;
        rx      = 1'b1;
        rd      = 1'b0;
        clr_err = 1'b0;
        step(3);
        reset = 1'b0;
        step(2);
        test_reset();
        test_single_byte();
        test_glitch();
        test_fill_overrun();
        test_framing();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
